// File: rtl/iq_tx_player_if.sv
// iq_tx_player_if: CPU-side command/data bus and strobed sample output of the
// I/Q transmit player.
//   master : the CPU / command side (drives writes, rate setup, run, clr_flags)
//   slave  : the player itself
// Signals: wr_i, wr_q, wr_data, set_rate, rate_div, interp_l, run, clr_flags
//          (master -> slave); out_strobe, out_i, out_q, level, full, empty,
//          overflow, underrun, dbg_state (slave -> master).
//
// Transfer semantics: there is no back-pressure on either side. wr_i, wr_q,
// set_rate and clr_flags are single-cycle pulses acted on in the cycle they
// are high. out_strobe is a one-cycle valid with no ready: out_i/out_q change
// only in a strobe cycle and hold until the next one.
interface iq_tx_player_if #(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = 10
);
  logic                  wr_i;
  logic                  wr_q;
  logic [W-1:0]          wr_data;
  logic                  set_rate;
  logic [15:0]           rate_div;
  logic [2:0]            interp_l;
  logic                  run;
  logic                  clr_flags;
  logic                  out_strobe;
  logic [W-1:0]          out_i;
  logic [W-1:0]          out_q;
  logic [DEPTH_LOG2:0]   level;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  underrun;
  logic [1:0]            dbg_state;

  modport master (
    output wr_i, wr_q, wr_data, set_rate, rate_div, interp_l, run, clr_flags,
    input  out_strobe, out_i, out_q, level, full, empty, overflow, underrun,
           dbg_state
  );

  modport slave (
    input  wr_i, wr_q, wr_data, set_rate, rate_div, interp_l, run, clr_flags,
    output out_strobe, out_i, out_q, level, full, empty, overflow, underrun,
           dbg_state
  );
endinterface

// File: rtl/iq_tx_player.sv
// iq_tx_player: buffers CPU-written I/Q pairs in a FIFO and plays them out in
// the adc_clk domain at a programmed rate, upsampling by 2^L with linear
// interpolation between consecutive pairs.
// Ports:
//   adc_clk : sole clock
//   reset   : synchronous active-high; clears FIFO, state, outputs, flags
//   bus     : iq_tx_player_if.slave (command/data inputs, strobed outputs,
//             FIFO status, sticky flags, dbg_state = current FSM state)
module iq_tx_player #(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int MAX_L      = 7
) (
  input  logic          adc_clk,
  input  logic          reset,
  iq_tx_player_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = W + 1 + MAX_L;
  localparam logic [2:0]            L_CLAMP  = 3'(MAX_L);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [MAX_L-1:0]      K_ONE    = {{(MAX_L-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_STARVE} state_t;

  state_t                r_state, w_state_n;
  logic [2*W-1:0]        r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [W-1:0]          r_hold_i;
  logic [15:0]           r_rate, r_cnt;
  logic [2:0]            r_l;
  logic [MAX_L-1:0]      r_k, w_k_n, w_k_inc, w_kmask;
  logic [2*W-1:0]        r_a, r_b, w_a_n, w_b_n, w_head;
  logic                  r_have_a, w_have_a_n;
  logic                  r_strobe, w_strobe_n;
  logic [W-1:0]          r_out_i, r_out_q, w_oi_n, w_oq_n, w_interp_i, w_interp_q;
  logic                  r_ovf, r_unf, w_unf_set, w_ovf_set;
  logic                  w_full, w_empty, w_tick, w_pop, w_push;

  // a + floor((b-a)*k / 2^l). The difference is W+1 bits and the product
  // PW bits, so nothing overflows; the arithmetic shift floors, which keeps
  // the result between a and b and lets it be truncated back to W bits.
  function automatic logic [W-1:0] interp(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [MAX_L-1:0] k,
                                          input logic [2:0] l);
    logic signed [PW-1:0] d, kk, p;
    d  = PW'($signed(b)) - PW'($signed(a));
    kk = PW'(k);
    p  = d * kk;
    return a + W'(p >>> l);
  endfunction

  assign w_full     = (r_level == LVL_FULL);
  assign w_empty    = (r_level == '0);
  assign w_head     = r_mem[r_rptr];
  assign w_tick     = ((r_state == S_RUN) || (r_state == S_STARVE)) && (r_cnt == 16'd0);
  assign w_kmask    = ~({MAX_L{1'b1}} << r_l);
  assign w_k_inc    = (r_k + K_ONE) & w_kmask;
  assign w_interp_i = interp(r_a[2*W-1:W], r_b[2*W-1:W], r_k, r_l);
  assign w_interp_q = interp(r_a[W-1:0], r_b[W-1:0], r_k, r_l);
  // A pop in the same cycle frees a slot, so a push while full is accepted.
  assign w_push     = bus.wr_q && (!w_full || w_pop);
  assign w_ovf_set  = bus.wr_q && w_full && !w_pop;

  always_comb begin
    w_state_n  = r_state;
    w_have_a_n = 1'b0;
    w_a_n      = r_a;
    w_b_n      = r_b;
    w_k_n      = r_k;
    w_pop      = 1'b0;
    w_strobe_n = 1'b0;
    w_oi_n     = r_out_i;
    w_oq_n     = r_out_q;
    w_unf_set  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.run) w_state_n = S_PRIME;
      S_PRIME: begin
        if (!bus.run) w_state_n = S_IDLE;
        else begin
          w_have_a_n = r_have_a;
          if (!w_empty) begin
            w_pop = 1'b1;
            if (!r_have_a) begin
              w_a_n      = w_head;
              w_have_a_n = 1'b1;
            end else begin
              w_b_n      = w_head;
              w_k_n      = '0;
              w_have_a_n = 1'b0;
              w_state_n  = S_RUN;
            end
          end
        end
      end
      S_RUN: begin
        if (!bus.run) w_state_n = S_IDLE;
        else if (w_tick) begin
          w_strobe_n = 1'b1;
          w_oi_n     = w_interp_i;
          w_oq_n     = w_interp_q;
          w_k_n      = w_k_inc;
          if (w_k_inc == '0) begin
            w_a_n = r_b;
            if (!w_empty) begin
              w_pop = 1'b1;
              w_b_n = w_head;
            end else begin
              // b is kept so STARVE can keep emitting the last sample.
              w_unf_set = 1'b1;
              w_state_n = S_STARVE;
            end
          end
        end
      end
      S_STARVE: begin
        if (!bus.run) w_state_n = S_IDLE;
        else if (w_tick) begin
          w_strobe_n = 1'b1;
          w_oi_n     = r_b[2*W-1:W];
          w_oq_n     = r_b[W-1:0];
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_a_n     = r_b;
            w_b_n     = w_head;
            w_k_n     = '0;
            w_state_n = S_RUN;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Sample storage carries no reset; the pointers define what is valid.
  always_ff @(posedge adc_clk) begin
    if (w_push) r_mem[r_wptr] <= {r_hold_i, bus.wr_data};
  end

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_hold_i <= '0;
      r_rate   <= '0;
      r_cnt    <= '0;
      r_l      <= '0;
      r_k      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_have_a <= 1'b0;
      r_strobe <= 1'b0;
      r_out_i  <= '0;
      r_out_q  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_have_a <= w_have_a_n;
      r_a      <= w_a_n;
      r_b      <= w_b_n;
      r_k      <= w_k_n;
      r_strobe <= w_strobe_n;
      r_out_i  <= w_oi_n;
      r_out_q  <= w_oq_n;
      if (bus.wr_i) r_hold_i <= bus.wr_data;
      if (w_push)   r_wptr   <= r_wptr + DEPTH_LOG2'(1);
      if (w_pop)    r_rptr   <= r_rptr + DEPTH_LOG2'(1);
      r_level <= r_level + {{DEPTH_LOG2{1'b0}}, w_push} - {{DEPTH_LOG2{1'b0}}, w_pop};
      if (bus.set_rate && !bus.run) begin
        r_rate <= bus.rate_div;
        r_l    <= (bus.interp_l > L_CLAMP) ? L_CLAMP : bus.interp_l;
      end
      // Held at rate_div outside RUN/STARVE, so PRIME always hands RUN a
      // freshly loaded counter.
      if ((r_state == S_IDLE) || (r_state == S_PRIME) || w_tick) r_cnt <= r_rate;
      else                                                      r_cnt <= r_cnt - 16'd1;
      r_ovf <= (r_ovf && !bus.clr_flags) || w_ovf_set;
      r_unf <= (r_unf && !bus.clr_flags) || w_unf_set;
    end
  end

  assign bus.out_strobe = r_strobe;
  assign bus.out_i      = r_out_i;
  assign bus.out_q      = r_out_q;
  assign bus.level      = r_level;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.overflow   = r_ovf;
  assign bus.underrun   = r_unf;
  assign bus.dbg_state  = r_state;
endmodule

// File: doc/iq_tx_player.md
Name: iq_tx_player

Overview:
- Transmit-direction counterpart of the waterfall/RX sampler path: the CPU pushes I/Q sample pairs and the block plays them out at a programmed rate in the adc_clk domain.
- It buffers pairs in a FIFO and upsamples by 2^L using linear interpolation between consecutive pairs.
- It emits strobed I/Q outputs for a downstream TX mixer/DAC path.
- Command pulses are already synchronised into adc_clk (SYNC_PULSE) by the instantiating module.

Parameters:
- W, 16, sample width of I and Q (two's complement).
- DEPTH_LOG2, 10, FIFO holds 2^DEPTH_LOG2 I/Q pairs.
- MAX_L, 7, maximum interpolation exponent; the factor is 2^L with L = 0..MAX_L.

Ports:
- adc_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high; clears FIFO, state, outputs and flags.
- wr_i  in  1  pulse: latch wr_data into the I holding register.
- wr_q  in  1  pulse: commit {held I, wr_data} as one pair to the FIFO.
- wr_data  in  W  write data.
- set_rate  in  1  pulse: load rate_div and interp_l; legal only while run=0, ignored otherwise.
- rate_div  in  16  adc_clk cycles per output sample, minus 1 (0 = every clock).
- interp_l  in  3  interpolation exponent L; values > MAX_L clamp to MAX_L.
- run  in  1  level: 1 = play, 0 = stop (returns to IDLE; FIFO contents kept).
- clr_flags  in  1  pulse: clear the overflow and underrun sticky flags.
- out_strobe  out  1  one-cycle pulse; out_i/out_q valid and held until the next strobe.
- out_i, out_q  out  W  interpolated output samples.
- level  out  DEPTH_LOG2+1  current FIFO occupancy in pairs.
- full, empty  out  1  FIFO status.
- overflow, underrun  out  1  sticky error flags.

Behaviour:
- Reset values: out_strobe=0, out_i=out_q=0, level=0, empty=1, full=0, overflow=0, underrun=0, state=IDLE, rate_div=0, L=0, a=b=0.
- Write side:
  - wr_q while not full pushes the pair; level increments in the next cycle.
  - wr_q while full drops the pair and sets overflow.
  - wr_i without a following wr_q is simply overwritten by the next wr_i.
  - A push and a pop in the same cycle leave level unchanged.
  - FIFO pointers wrap modulo 2^DEPTH_LOG2; full is level == 2^DEPTH_LOG2.
- Tick generator: a 16-bit down-counter reloads rate_div and asserts tick when it reaches 0. It runs only in RUN/STARVE and is reloaded on entry to PRIME.
- State machine:
  - IDLE: outputs hold. run=1 -> PRIME.
  - PRIME: pop two pairs, into a then b, one per cycle as soon as they are available; phase k=0. After the second pop -> RUN. run=0 -> IDLE.
  - RUN: on tick, output a + (((b-a)*k) >>> L).
    - Difference is W+1 bits and the product is W+1+MAX_L bits; the arithmetic shift floors, so the result always lies between a and b.
    - k increments modulo 2^L.
    - When k wraps to 0 in the same tick: a<=b, b<=FIFO head (pop).
    - If the FIFO is empty at pop time: set underrun, a<=b, keep b, enter STARVE.
  - STARVE: on each tick output b (constant) with a strobe. When level>=1, pop into b on the next tick boundary with k=0 and return to RUN. run=0 -> IDLE.
- With L=0 the output equals a on each tick and a new pair is popped every tick (pure pass-through).
- Latency:
  - out_strobe is registered, asserted exactly 1 cycle after tick, and out_i/out_q update in that same cycle.
  - The first strobe after run rises comes no earlier than 3 cycles (PRIME pops + tick) when rate_div=0.
- set_rate is ignored while run=1.
- reset mid-operation: all state returns to reset values in the next cycle; no strobe is issued in that cycle.
- clr_flags and a new flag event in the same cycle: the flag ends up set (set wins).

Test Plan:
- Basic playback, L=0, rate_div=0: push pairs (1,-1),(2,-2),(3,-3),(4,-4), run=1 -> strobes on consecutive cycles output I=1,2,3,4 and Q=-1,-2,-3,-4; underrun then sets and out_i holds 4.
- Interpolation, L=2, rate_div=3: push I=0,100,-100 -> out_i sequence 0,25,50,75,100,50,0,-50 with strobes 4 cycles apart. Also push I=0,-1 with L=2 -> outputs 0,-1,-1,-1 (floor).
- Overflow: DEPTH_LOG2=4; push 17 pairs without run -> level=16, full=1, overflow=1, 17th pair absent. clr_flags -> overflow=0.
- Underrun recovery: run with 2 pairs, L=1 -> STARVE, underrun=1, constant output. Push one pair -> RUN resumes, interpolating from the held value, with no missed strobe.
- Simultaneous push/pop at level=5 -> level stays 5. Push while full coincident with a pop -> pop occurs, push accepted, overflow=0.
- Reset mid-RUN at k=2: reset pulse -> next cycle level=0, out_i=0, out_strobe=0, state IDLE. set_rate with run=1 leaves rate_div unchanged.
